// File: rtl/mfp_uart_transmitter.sv
// rtl/mfp_uart_transmitter.sv - 8N1 UART transmitter with byte FIFO and fixed baud divisor
module mfp_uart_transmitter #(
  parameter int DIVISOR = 434,
  parameter int FIFO_AW = 3
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             uart_tx,
  output logic             busy,
  output logic [FIFO_AW:0] fifo_count
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   DEPTH_V     = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]   CNT_ONE     = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE     = FIFO_AW'(1);
  localparam logic [15:0]        BAUD_RELOAD = 16'(DIVISOR - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic [1:0]         state;
  logic [15:0]        baud_cnt;
  logic [2:0]         bit_idx;
  logic [7:0]         shift_reg;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic               bit_end;

  assign full       = (count == DEPTH_V);
  assign empty      = (count == '0);
  assign push       = tx_valid && !full;
  assign bit_end    = (baud_cnt == '0);
  // The FSM pops either from idle or at the end of a stop bit so frames chain without a gap.
  assign pop        = !empty && ((state == ST_IDLE) || ((state == ST_STOP) && bit_end));
  assign tx_ready   = !full;
  assign fifo_count = count;

  always_ff @(posedge HCLK) begin
    if (push) begin
      mem[wr_ptr] <= tx_data;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state     <= ST_IDLE;
      uart_tx   <= 1'b1;
      busy      <= 1'b0;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            shift_reg <= mem[rd_ptr];
            uart_tx   <= 1'b0;
            baud_cnt  <= BAUD_RELOAD;
            busy      <= 1'b1;
            state     <= ST_START;
          end
        end
        ST_START: begin
          if (bit_end) begin
            uart_tx  <= shift_reg[0];
            bit_idx  <= '0;
            baud_cnt <= BAUD_RELOAD;
            state    <= ST_DATA;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            baud_cnt <= BAUD_RELOAD;
            if (bit_idx != 3'd7) begin
              shift_reg <= shift_reg >> 1;
              uart_tx   <= shift_reg[1];
              bit_idx   <= bit_idx + 3'd1;
            end else begin
              uart_tx <= 1'b1;
              state   <= ST_STOP;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        default: begin
          if (bit_end) begin
            if (pop) begin
              shift_reg <= mem[rd_ptr];
              uart_tx   <= 1'b0;
              baud_cnt  <= BAUD_RELOAD;
              state     <= ST_START;
            end else begin
              busy  <= 1'b0;
              state <= ST_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mfp_uart_transmitter.sv
// tb/tb_mfp_uart_transmitter.sv - self-checking bench for mfp_uart_transmitter
module tb_mfp_uart_transmitter;

  localparam int DEPTH   = 8;
  localparam int BIG_DIV = 65535;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn;
  logic [7:0] td;
  logic       tv0, tv1, tv2;
  logic       rdy0, rdy1, rdy2;
  logic       ut0, ut1, ut2;
  logic       bz0, bz1, bz2;
  logic [3:0] fc0, fc1, fc2;

  logic       rstn_b;
  logic [7:0] tdb0, tdb1;
  logic       tvb0, tvb1;
  logic       rdyb0, rdyb1, utb0, utb1, bzb0, bzb1;
  logic [3:0] fcb0, fcb1;

  mfp_uart_transmitter #(.DIVISOR(4), .FIFO_AW(3)) dut4 (
    .HCLK(clk), .HRESETn(rstn), .tx_data(td), .tx_valid(tv0), .tx_ready(rdy0),
    .uart_tx(ut0), .busy(bz0), .fifo_count(fc0));
  mfp_uart_transmitter #(.DIVISOR(8), .FIFO_AW(3)) dut8 (
    .HCLK(clk), .HRESETn(rstn), .tx_data(td), .tx_valid(tv1), .tx_ready(rdy1),
    .uart_tx(ut1), .busy(bz1), .fifo_count(fc1));
  mfp_uart_transmitter #(.DIVISOR(2), .FIFO_AW(3)) dut2 (
    .HCLK(clk), .HRESETn(rstn), .tx_data(td), .tx_valid(tv2), .tx_ready(rdy2),
    .uart_tx(ut2), .busy(bz2), .fifo_count(fc2));
  mfp_uart_transmitter #(.DIVISOR(BIG_DIV), .FIFO_AW(3)) dutb0 (
    .HCLK(clk), .HRESETn(rstn_b), .tx_data(tdb0), .tx_valid(tvb0), .tx_ready(rdyb0),
    .uart_tx(utb0), .busy(bzb0), .fifo_count(fcb0));
  mfp_uart_transmitter #(.DIVISOR(BIG_DIV), .FIFO_AW(3)) dutb1 (
    .HCLK(clk), .HRESETn(rstn_b), .tx_data(tdb1), .tx_valid(tvb1), .tx_ready(rdyb1),
    .uart_tx(utb1), .busy(bzb1), .fifo_count(fcb1));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         sel = 0;
  int         mon_div = 4;
  logic       mon_line, mon_busy, mon_rdy;
  logic [3:0] mon_cnt;

  always_comb begin
    mon_line = ut0; mon_busy = bz0; mon_rdy = rdy0; mon_cnt = fc0;
    case (sel)
      1: begin mon_line = ut1; mon_busy = bz1; mon_rdy = rdy1; mon_cnt = fc1; end
      2: begin mon_line = ut2; mon_busy = bz2; mon_rdy = rdy2; mon_cnt = fc2; end
      default: ;
    endcase
  end

  task automatic drive_valid(input int s, input logic v);
    case (s)
      1: tv1 = v;
      2: tv2 = v;
      default: tv0 = v;
    endcase
  endtask

  // Frame decoder: a frame starts at the first low sample; every bit must hold for mon_div samples.
  typedef struct {
    logic [9:0] bits;
    int         start;
    int         glitch;
    int         busy_bad;
  } frame_t;

  frame_t mon_q[$];
  bit     mon_en = 1'b0;

  initial begin : monitor
    int     pos;
    bit     in_f;
    frame_t f;
    in_f = 1'b0;
    pos = 0;
    f = '{bits: '0, start: 0, glitch: 0, busy_bad: 0};
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        in_f = 1'b0;
      end else if (!in_f) begin
        if (mon_line == 1'b0) begin
          in_f = 1'b1;
          pos = 0;
          f.bits = '0;
          f.start = cyc;
          f.glitch = 0;
          f.busy_bad = (mon_busy !== 1'b1) ? 1 : 0;
        end
      end else begin
        pos++;
        if (pos % mon_div == 0) f.bits[pos / mon_div] = mon_line;
        else if (mon_line !== f.bits[pos / mon_div]) f.glitch++;
        if (mon_busy !== 1'b1) f.busy_bad++;
        if (pos == 10 * mon_div - 1) begin
          mon_q.push_back(f);
          in_f = 1'b0;
        end
      end
    end
  end

  logic       stim_v[$];
  logic [7:0] stim_d[$];
  int         obs_count[$];
  int         exp_start[$];
  logic [7:0] exp_byte[$];

  // Reference: byte n starts at max(accept+1, previous start + 10*D); count = accepted bytes not yet started.
  task automatic run_stream(input int s, input int d);
    int  base, t, tt, last_s, pend;
    bit  done;
    sel = s;
    mon_div = d;
    mon_q.delete();
    obs_count.delete();
    exp_start.delete();
    exp_byte.delete();
    mon_en = 1'b1;
    @(negedge clk);
    base = cyc + 1;
    last_s = -1000000;
    t = 0;
    tt = base;
    done = 1'b0;
    while (!done) begin
      tt = base + t;
      pend = 0;
      foreach (exp_start[k]) if (exp_start[k] >= tt) pend++;
      td = 8'h00;
      drive_valid(s, 1'b0);
      if (t < stim_v.size() && stim_v[t]) begin
        td = stim_d[t];
        drive_valid(s, 1'b1);
        if (pend < DEPTH) begin
          last_s = (tt + 1 > last_s + 10 * d) ? tt + 1 : last_s + 10 * d;
          exp_start.push_back(last_s);
          exp_byte.push_back(stim_d[t]);
        end
      end
      @(negedge clk);
      pend = 0;
      foreach (exp_start[k]) if (exp_start[k] > tt) pend++;
      obs_count.push_back(int'(mon_cnt));
      chk("fifo_count", mon_cnt, pend);
      chk("tx_ready", mon_rdy, (pend < DEPTH) ? 1 : 0);
      t++;
      if (t >= stim_v.size() && tt >= last_s + 10 * d + 1) done = 1'b1;
    end
    drive_valid(s, 1'b0);
    chk("idle line after stream", mon_line, 1);
    chk("idle busy after stream", mon_busy, 0);
    chk("frame count", mon_q.size(), exp_byte.size());
    for (int k = 0; k < mon_q.size() && k < exp_byte.size(); k++) begin
      chk("frame bits", mon_q[k].bits, {1'b1, exp_byte[k], 1'b0});
      chk("frame start", mon_q[k].start, exp_start[k]);
      chk("frame glitch", mon_q[k].glitch, 0);
      chk("frame busy", mon_q[k].busy_bad, 0);
    end
    mon_en = 1'b0;
    stim_v.delete();
    stim_d.delete();
  endtask

  typedef struct {
    int         s;
    int         d;
    logic [7:0] data;
    logic [9:0] frame;
  } vec_t;

  vec_t vecs[5];
  bit   big_done = 1'b0;

  initial begin : main
    int e0, w, lows;
    vecs[0] = '{s: 0, d: 4, data: 8'h55, frame: 10'h2AA};
    vecs[1] = '{s: 0, d: 4, data: 8'h0F, frame: 10'h21E};
    vecs[2] = '{s: 1, d: 8, data: 8'hA3, frame: 10'h346};
    vecs[3] = '{s: 2, d: 2, data: 8'hC6, frame: 10'h38C};
    vecs[4] = '{s: 0, d: 4, data: 8'h80, frame: 10'h300};

    rstn = 1'b0; td = 8'h00; tv0 = 1'b0; tv1 = 1'b0; tv2 = 1'b0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk("reset uart_tx", mon_line, 1);
      chk("reset busy", mon_busy, 0);
      chk("reset fifo_count", mon_cnt, 0);
      chk("reset tx_ready", mon_rdy, 1);
    end
    rstn = 1'b1;

    // Single-byte frames against hand-computed line patterns
    for (int i = 0; i < 5; i++) begin
      sel = vecs[i].s;
      mon_div = vecs[i].d;
      mon_q.delete();
      mon_en = 1'b1;
      @(negedge clk);
      td = vecs[i].data;
      drive_valid(vecs[i].s, 1'b1);
      @(negedge clk);
      drive_valid(vecs[i].s, 1'b0);
      e0 = cyc;
      chk("tbl count after push", mon_cnt, 1);
      for (w = 0; w < 12 * vecs[i].d + 4 && mon_q.size() == 0; w++) begin
        @(negedge clk);
        #2;
      end
      chk("tbl frame seen", mon_q.size(), 1);
      if (mon_q.size() > 0) begin
        chk("tbl frame bits", mon_q[0].bits, vecs[i].frame);
        chk("tbl start latency", mon_q[0].start, e0 + 1);
        chk("tbl glitch", mon_q[0].glitch, 0);
        chk("tbl busy", mon_q[0].busy_bad, 0);
      end
      @(negedge clk);
      chk("tbl idle line", mon_line, 1);
      chk("tbl idle busy", mon_busy, 0);
      mon_en = 1'b0;
    end

    // Back-to-back: three consecutive pushes
    stim_v = '{1'b1, 1'b1, 1'b1};
    stim_d = '{8'hA3, 8'h00, 8'hFF};
    run_stream(0, 4);
    chk("b2b obs size", (obs_count.size() > 81) ? 1 : 0, 1);
    if (obs_count.size() > 81) begin
      chk("b2b count0", obs_count[0], 1);
      chk("b2b count1", obs_count[1], 1);
      chk("b2b count2", obs_count[2], 2);
      chk("b2b count40", obs_count[40], 2);
      chk("b2b count41", obs_count[41], 1);
      chk("b2b count81", obs_count[81], 0);
    end
    if (mon_q.size() == 3) chk("b2b span", mon_q[2].start + 40 - mon_q[0].start, 120);

    // Push exactly on the STOP->START edge of the first frame
    for (int t = 0; t < 42; t++) begin
      stim_v.push_back(t < 3 || t == 41);
      stim_d.push_back((t == 41) ? 8'hD4 : 8'hA1 + 8'(t));
    end
    run_stream(0, 4);
    if (obs_count.size() > 41) begin
      chk("simul count before", obs_count[40], 2);
      chk("simul count on edge", obs_count[41], 2);
    end

    // Full FIFO: ten pushes with valid held, last one dropped
    for (int t = 0; t < 10; t++) begin
      stim_v.push_back(1'b1);
      stim_d.push_back(8'(t + 1));
    end
    run_stream(1, 8);
    if (obs_count.size() > 9) begin
      chk("full count t8", obs_count[8], 8);
      chk("full count t9", obs_count[9], 8);
    end
    chk("full frames", mon_q.size(), 9);
    if (mon_q.size() == 9) chk("full last byte", mon_q[8].bits[8:1], 9);

    // Reset during data bit 3
    sel = 0;
    @(negedge clk);
    td = 8'h0F; tv0 = 1'b1;
    @(negedge clk);
    tv0 = 1'b0;
    chk("rst-mid count", fc0, 1);
    @(negedge clk);
    chk("rst-mid start bit", ut0, 0);
    repeat (17) @(negedge clk);
    chk("rst-mid bit3 level", ut0, 1);
    chk("rst-mid busy before", bz0, 1);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    chk("rst-mid uart_tx", ut0, 1);
    chk("rst-mid busy", bz0, 0);
    chk("rst-mid fifo_count", fc0, 0);
    chk("rst-mid tx_ready", rdy0, 1);
    lows = 0;
    repeat (50) begin
      @(negedge clk);
      if (ut0 !== 1'b1 || bz0 !== 1'b0) lows++;
    end
    chk("rst-mid quiet line", lows, 0);
    stim_v = '{1'b1};
    stim_d = '{8'h80};
    run_stream(0, 4);

    stim_v = '{1'b1};
    stim_d = '{8'hC6};
    run_stream(2, 2);

    // Randomized traffic against the reference model
    for (int t = 0; t < 400; t++) begin
      stim_v.push_back($urandom_range(0, 99) < 45);
      stim_d.push_back(8'($urandom));
    end
    run_stream(0, 4);
    for (int t = 0; t < 300; t++) begin
      stim_v.push_back($urandom_range(0, 99) < 20);
      stim_d.push_back(8'($urandom));
    end
    run_stream(1, 8);

    for (w = 0; w < 70000 && !big_done; w++) @(negedge clk);
    chk("big divisor finished", big_done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : big_divisor
    int bad0, bad1;
    rstn_b = 1'b0; tvb0 = 1'b0; tvb1 = 1'b0; tdb0 = 8'hC6; tdb1 = 8'hFF;
    repeat (2) @(negedge clk);
    rstn_b = 1'b1;
    @(negedge clk);
    tvb0 = 1'b1; tvb1 = 1'b1;
    @(negedge clk);
    tvb0 = 1'b0; tvb1 = 1'b0;
    chk("big count after push", fcb0, 1);
    chk("big ready after push", rdyb0, 1);
    @(negedge clk);
    chk("big start low", utb0, 0);
    chk("big busy", bzb0, 1);
    chk("big count after pop", fcb1, 0);
    chk("big ready after pop", rdyb1, 1);
    bad0 = 0;
    bad1 = 0;
    for (int c = 1; c < BIG_DIV; c++) begin
      @(negedge clk);
      if (utb0 !== 1'b0 || bzb0 !== 1'b1) bad0++;
      if (utb1 !== 1'b0 || bzb1 !== 1'b1) bad1++;
    end
    chk("big start width 0xC6", bad0, 0);
    chk("big start width 0xFF", bad1, 0);
    @(negedge clk);
    chk("big bit0 of 0xC6", utb0, 0);
    chk("big bit0 of 0xFF", utb1, 1);
    big_done = 1'b1;
  end

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/mfp_uart_transmitter.md
# mfp_uart_transmitter

Byte-oriented 8N1 UART transmitter with an internal FIFO that drives the board's `UART_TX` pin, which the DE1 top level currently leaves unconnected. It sits between the system's I/O interface, which pushes bytes through a valid/ready handshake, and the board top, which routes `uart_tx` to the chosen GPIO pin. The block buffers bytes, serialises them LSB first at a fixed divisor of the system clock, and reports occupancy and activity.

## Interface
- `DIVISOR`, default 434: system clocks per bit (50 MHz / 115200). Legal range 2..65535.
- `FIFO_AW`, default 3: FIFO address width. Depth is 2**FIFO_AW (8 by default).
- `HCLK` input, 1 bit: system clock. The block uses only this clock; all state changes on its rising edge.
- `HRESETn` input, 1 bit: reset, synchronous and active-low.
- `tx_data` input, 8 bits: byte to transmit.
- `tx_valid` input, 1 bit: `tx_data` is valid this cycle.
- `tx_ready` output, 1 bit: the FIFO can accept a byte. Defined as `!full`, combinational from registered state.
- `uart_tx` output, 1 bit: serial line. Registered, idles high.
- `busy` output, 1 bit: a frame is in progress (state ≠ IDLE). Registered.
- `fifo_count` output, FIFO_AW+1 bits: number of bytes queued. Does not include the byte being shifted.

## Operation
- **Push:** when `tx_valid && tx_ready` at an edge, `tx_data` is written at the write pointer. Pointers wrap modulo depth. Count is FIFO_AW+1 bits wide; `full` is count == depth and `empty` is count == 0.
- **Push while full:** the push is ignored and the data is dropped, with no error flag. `tx_ready` is low, so a compliant master holds.
- **Pop:** performed by the FSM only.
  - Push and pop on the same edge leave the count unchanged.
  - When full, push is blocked even if a pop occurs on the same edge.
- **FSM states:** IDLE, START, DATA, STOP.
- **IDLE:** `uart_tx`=1 and `busy`=0. If the FIFO is non-empty at an edge:
  - pop the head into the 8-bit shift register;
  - set `uart_tx` to 0 and `baud_cnt` to DIVISOR-1;
  - go to START.
- **Bit timer:** `baud_cnt` counts down one per cycle. Reaching 0 marks the end of the current bit; the counter then reloads to DIVISOR-1.
- **START → DATA:** at end of bit, drive shift[0] and set `bit_idx` to 0.
- **DATA:** at end of bit:
  - if `bit_idx` < 7, shift right, drive the new shift[0], and increment `bit_idx`;
  - if `bit_idx` = 7, drive `uart_tx`=1 and go to STOP.
- **STOP:** at end of bit:
  - if the FIFO is non-empty, pop and go directly to START with `uart_tx`=0, so frames run back-to-back with no idle gap;
  - otherwise go to IDLE with `uart_tx` staying at 1.
- **Frame format:** 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Every bit is exactly DIVISOR cycles, so a frame is 10·DIVISOR cycles.
- **Reset mid-operation:** all state is discarded on the reset edge:
  - FIFO emptied and pointers zeroed;
  - FSM set to IDLE;
  - `uart_tx`=1 from the cycle after the reset edge, even mid-frame, so the truncated frame is simply abandoned.

## Timing
- **Reset values:** `uart_tx`=1, `busy`=0, `fifo_count`=0, `tx_ready`=1, FSM=IDLE, `baud_cnt`=0, shift register=0.
- **Latency:** with the FIFO empty and the FSM IDLE, a byte accepted at edge E0 appears as `fifo_count`=1 after E0. At E1 it is popped: `uart_tx` falls, `busy` rises and `fifo_count` returns to 0.
- **Bit boundaries:** start bit occupies cycles E1..E1+DIVISOR-1. Data bit k begins at E1+(k+1)·DIVISOR. Stop bit begins at E1+9·DIVISOR. FSM re-enters IDLE, or START for the next frame, at E1+10·DIVISOR.
- **Back-to-back frames:** the next start bit begins exactly at E1+10·DIVISOR.
- **`tx_ready`:** reflects the current count. It rises in the cycle after a pop from a full FIFO.

## Test plan
- **Single byte:** DIVISOR=4. Push 0x55 at E0 → `uart_tx` pattern 0,1,0,1,0,1,0,1,0,1, each level held 4 cycles starting after E1. `busy` high for 40 cycles, then `uart_tx`=1 and `busy`=0.
- **Back-to-back:** DIVISOR=4. Push 0xA3, 0x00, 0xFF on consecutive cycles → three frames, 120 cycles total, with no idle-high gap between stop and start bits. `fifo_count` sequence after pushes is 1,1,2, then decrements at each frame boundary.
- **Full FIFO:** DIVISOR=8, depth 8. Push 10 bytes 0x01..0x0A with `tx_valid` held high and ignoring `tx_ready`:
  - first byte is popped immediately;
  - `tx_ready` falls when count reaches 8 (bytes 0x02..0x09 queued);
  - 0x0A is dropped;
  - transmitted sequence is 0x01..0x09.
- **Simultaneous push/pop:** DIVISOR=4, FIFO holding 2 bytes. Push a byte on the exact STOP→START edge → `fifo_count` stays 2 and all bytes are transmitted in order.
- **Reset mid-frame:** push 0x0F, then assert `HRESETn`=0 for one edge during data bit 3 → `uart_tx`=1, `busy`=0, `fifo_count`=0 the next cycle. A new push of 0x80 produces a clean frame.
- **Divisor sweep:** DIVISOR=2 and DIVISOR=65535 with byte 0xC6 → bit widths measured exactly 2 and 65535 cycles, with correct LSB-first data.
